// File: rtl/bisr_pkg.sv
// Shared types for the BISR weight allocator: FSM states, fault table entry
// layout and a lowest-set-bit helper used by the row selector.
package bisr_pkg;

  localparam int P_ROWS        = 8;
  localparam int P_COLS        = 8;
  localparam int P_WEIGHT_W    = 8;
  localparam int P_FAULT_DEPTH = 8;
  localparam int P_ADDR_W      = $clog2(P_ROWS);
  localparam int P_FIDX_W      = $clog2(P_FAULT_DEPTH);

  typedef enum logic [1:0] {IDLE, PREP, LOAD, READY} state_t;

  typedef struct packed {
    logic                vld;
    logic [P_ADDR_W-1:0] row;
    logic [P_COLS-1:0]   mask;
  } fault_entry_t;

  typedef struct packed {
    logic                found;
    logic [P_ADDR_W-1:0] idx;
  } lsb_t;

  function automatic lsb_t lowest_set(input logic [P_ROWS-1:0] v);
    lsb_t r;
    r = '0;
    for (int i = P_ROWS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = P_ADDR_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bisr_row_selector.sv
// Combinational choice of the physical row for the current logical row,
// preferring faulty rows whose faults only hit zero weights.
module bisr_row_selector
  import bisr_pkg::*;
#(
  parameter int ROWS   = P_ROWS,
  parameter int COLS   = P_COLS,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]   free,
  input  logic [COLS-1:0]   row_mask [ROWS],
  input  logic [COLS-1:0]   zero,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] lc,
  output logic [ADDR_W-1:0] phys,
  output logic              fail
);

  logic [ROWS-1:0] fit;
  logic [ROWS-1:0] clean;
  lsb_t            f_fit;
  lsb_t            f_clean;
  lsb_t            f_free;

  always_comb begin
    fit   = '0;
    clean = '0;
    for (int r = 0; r < ROWS; r++) begin
      fit[r]   = free[r] && (row_mask[r] != '0) && ((row_mask[r] & ~zero) == '0);
      clean[r] = free[r] && (row_mask[r] == '0);
    end
  end

  assign f_fit   = lowest_set(fit);
  assign f_clean = lowest_set(clean);
  assign f_free  = lowest_set(free);

  always_comb begin
    phys = lc;
    fail = 1'b0;
    if (alloc_en) begin
      if (f_fit.found) begin
        phys = f_fit.idx;
      end else if (f_clean.found) begin
        phys = f_clean.idx;
      end else begin
        // Nothing safe left: still place the row so the tile completes.
        fail = 1'b1;
        phys = f_free.idx;
      end
    end
  end

endmodule

// File: rtl/bisr_weight_allocator_pp.sv
// Ping-pong BISR weight allocator: loads a tile into the shadow bank with
// fault-aware row remapping while the active bank serves reads.
module bisr_weight_allocator_pp
  import bisr_pkg::*;
#(
  parameter int ROWS         = P_ROWS,
  parameter int COLS         = P_COLS,
  parameter int WEIGHT_WIDTH = P_WEIGHT_W,
  parameter int FAULT_DEPTH  = P_FAULT_DEPTH,
  parameter int ADDR_W       = $clog2(ROWS),
  parameter int FIDX_W       = $clog2(FAULT_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic                         fault_wr_en,
  input  logic [FIDX_W-1:0]            fault_wr_idx,
  input  logic [ADDR_W-1:0]            fault_wr_row,
  input  logic [COLS-1:0]              fault_wr_mask,
  input  logic                         fault_wr_vld,
  input  logic                         fault_clr,
  output logic                         fault_wr_err,
  input  logic                         start,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [COLS*WEIGHT_WIDTH-1:0] w_data,
  input  logic                         swap,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_valid,
  output logic [COLS*WEIGHT_WIDTH-1:0] rd_data,
  output logic [ADDR_W-1:0]            rd_mapped_addr,
  output logic                         busy,
  output logic                         shadow_ready,
  output logic                         alloc_done,
  output logic                         alloc_success,
  output logic                         active_bank
);

  localparam int DW = COLS * WEIGHT_WIDTH;

  state_t            state, state_n;
  fault_entry_t      ftab     [FAULT_DEPTH];
  logic [COLS-1:0]   row_mask [ROWS];
  logic [COLS-1:0]   merged   [ROWS];
  logic [DW-1:0]     bank     [2][ROWS];
  logic [ADDR_W-1:0] map      [2][ROWS];
  logic [ROWS-1:0]   free;
  logic [ADDR_W-1:0] lc;
  logic              fail;
  logic              en_q;
  logic              any_vld;
  logic [COLS-1:0]   zero;
  logic [ADDR_W-1:0] sel_phys;
  logic              sel_fail;
  logic              accept;
  logic              last;
  logic              shadow;

  // Handshake: a weight row transfers on a cycle where w_valid && w_ready,
  // except when start aborts the tile in that same cycle.
  assign w_ready      = (state == LOAD);
  assign busy         = (state == PREP) || (state == LOAD);
  assign shadow_ready = (state == READY);
  assign accept       = (state == LOAD) && w_valid && !start;
  assign last         = accept && (lc == ADDR_W'(ROWS - 1));
  assign shadow       = ~active_bank;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      zero[c] = (w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0);
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      merged[r] = '0;
    end
    for (int e = 0; e < FAULT_DEPTH; e++) begin
      any_vld = any_vld | ftab[e].vld;
      for (int r = 0; r < ROWS; r++) begin
        if (ftab[e].vld && (ftab[e].row == ADDR_W'(r))) begin
          merged[r] = merged[r] | ftab[e].mask;
        end
      end
    end
  end

  bisr_row_selector #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) u_sel (
    .free     (free),
    .row_mask (row_mask),
    .zero     (zero),
    .alloc_en (en_q),
    .lc       (lc),
    .phys     (sel_phys),
    .fail     (sel_fail)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = PREP;
      PREP:    state_n = start ? PREP : LOAD;
      LOAD:    if (start) state_n = PREP;
               else if (last) state_n = READY;
      READY:   if (swap) state_n = IDLE;
               else if (start) state_n = PREP;
      default: state_n = IDLE;
    endcase
  end

  // Weight storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept) bank[shadow][sel_phys] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < FAULT_DEPTH; e++) ftab[e] <= '0;
      for (int r = 0; r < ROWS; r++) begin
        row_mask[r] <= '0;
        map[0][r]   <= ADDR_W'(r);
        map[1][r]   <= ADDR_W'(r);
      end
      free           <= '0;
      lc             <= '0;
      fail           <= 1'b0;
      en_q           <= 1'b0;
      alloc_done     <= 1'b0;
      alloc_success  <= 1'b0;
      active_bank    <= 1'b0;
      fault_wr_err   <= 1'b0;
      rd_valid       <= 1'b0;
      rd_mapped_addr <= '0;
      rd_data        <= '0;
    end else begin
      alloc_done   <= last;
      fault_wr_err <= (fault_wr_en || fault_clr) && (state != IDLE);
      if (state == IDLE) begin
        if (fault_clr) begin
          for (int e = 0; e < FAULT_DEPTH; e++) ftab[e].vld <= 1'b0;
        end
        if (fault_wr_en) begin
          ftab[fault_wr_idx] <= '{vld: fault_wr_vld, row: fault_wr_row, mask: fault_wr_mask};
        end
      end
      if (state == PREP) begin
        for (int r = 0; r < ROWS; r++) row_mask[r] <= merged[r];
        free <= '1;
        lc   <= '0;
        en_q <= alloc_en;
        // Bypass with a populated table leaves known faults unrepaired.
        fail <= !alloc_en && any_vld;
      end
      if (accept) begin
        map[shadow][lc] <= sel_phys;
        free[sel_phys]  <= 1'b0;
        lc              <= lc + 1'b1;
        if (sel_fail) fail <= 1'b1;
        if (last) alloc_success <= !(fail || sel_fail);
      end
      if ((state == READY) && swap) active_bank <= ~active_bank;
      if (rd_en) begin
        rd_valid       <= 1'b1;
        rd_mapped_addr <= map[active_bank][rd_addr];
        rd_data        <= bank[active_bank][map[active_bank][rd_addr]];
      end
    end
  end

endmodule
